// File: rtl/echo_arb.sv
// rtl/echo_arb.sv - two-requester, one-entry-slot arbiter onto heard / heard2 sinks
module echo_arb (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        req0__ENA,
    input  logic        req0_type,
    input  logic [31:0] req0_data,
    output logic        req0__RDY,
    input  logic        req1__ENA,
    input  logic        req1_type,
    input  logic [31:0] req1_data,
    output logic        req1__RDY,
    input  logic        enable,
    output logic        heard__ENA,
    output logic [31:0] heard_v,
    input  logic        heard__RDY,
    output logic        heard2__ENA,
    output logic [15:0] heard2_a,
    output logic [15:0] heard2_b,
    input  logic        heard2__RDY,
    output logic [15:0] count0,
    output logic [15:0] count1,
    output logic        err
);

    logic        full0, full1;
    logic        type0, type1;
    logic [31:0] data0, data1;
    logic        last;
    logic [15:0] cnt0, cnt1;
    logic        err_q;

    logic        elig0, elig1;
    logic        grant0, grant1, grant_any;
    logic        grant_type;
    logic [31:0] grant_data;

    assign req0__RDY = !full0;
    assign req1__RDY = !full1;
    assign count0    = cnt0;
    assign count1    = cnt1;
    assign err       = err_q;

    // A requester only competes when its own sink can take the message,
    // so a stalled sink never blocks the other requester.
    assign elig0 = full0 && enable && (type0 ? heard2__RDY : heard__RDY);
    assign elig1 = full1 && enable && (type1 ? heard2__RDY : heard__RDY);

    // On a tie, the requester that did not win most recently goes first.
    assign grant0    = elig0 && (!elig1 || last);
    assign grant1    = elig1 && (!elig0 || !last);
    assign grant_any = grant0 || grant1;

    always_comb begin
        grant_type  = 1'b0;
        grant_data  = 32'd0;
        heard__ENA  = 1'b0;
        heard_v     = 32'd0;
        heard2__ENA = 1'b0;
        heard2_a    = 16'd0;
        heard2_b    = 16'd0;
        if (grant0) begin
            grant_type = type0;
            grant_data = data0;
        end else if (grant1) begin
            grant_type = type1;
            grant_data = data1;
        end
        if (grant_any && !grant_type) begin
            heard__ENA = 1'b1;
            heard_v    = grant_data;
        end
        if (grant_any && grant_type) begin
            heard2__ENA = 1'b1;
            heard2_a    = grant_data[31:16];
            heard2_b    = grant_data[15:0];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            full0 <= 1'b0;
            full1 <= 1'b0;
            type0 <= 1'b0;
            type1 <= 1'b0;
            data0 <= 32'd0;
            data1 <= 32'd0;
            last  <= 1'b1;
            cnt0  <= 16'd0;
            cnt1  <= 16'd0;
            err_q <= 1'b0;
        end else begin
            // A granted slot empties here; RDY was low so nothing refills it this edge.
            if (grant0) begin
                full0 <= 1'b0;
            end else if (req0__ENA && !full0) begin
                full0 <= 1'b1;
                type0 <= req0_type;
                data0 <= req0_data;
            end
            if (grant1) begin
                full1 <= 1'b0;
            end else if (req1__ENA && !full1) begin
                full1 <= 1'b1;
                type1 <= req1_type;
                data1 <= req1_data;
            end
            if ((req0__ENA && full0) || (req1__ENA && full1))
                err_q <= 1'b1;
            if (grant_any)
                last <= grant1;
            if (grant0 && cnt0 != 16'hFFFF)
                cnt0 <= cnt0 + 16'd1;
            if (grant1 && cnt1 != 16'hFFFF)
                cnt1 <= cnt1 + 16'd1;
        end
    end

endmodule
